// File: rtl/alu.sv
// rtl/alu.sv - 8-bit eight-function ALU with registered result and carry/flag
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] op1,
    input  logic [7:0] op2,
    input  logic [2:0] sel,
    output logic [7:0] out,
    output logic       co
);

    typedef enum logic [2:0] {
        SEL_ADD    = 3'b000,
        SEL_ASHL   = 3'b001,
        SEL_XNOR   = 3'b010,
        SEL_DIV2   = 3'b011,
        SEL_LOAD   = 3'b100,
        SEL_STORE  = 3'b101,
        SEL_COMP2S = 3'b110,
        SEL_ROUND  = 3'b111
    } sel_e;

    logic [7:0] out_d, out_q;
    logic       co_d, co_q;
    logic [8:0] res;
    logic [8:0] round_sum;

    always_comb begin
        res       = 9'd0;
        round_sum = {1'b0, op1} + 9'd7;
        case (sel_e'(sel))
            SEL_ADD:    res = {1'b0, op1} + {1'b0, op2};
            SEL_ASHL:   res = {op1[7], op1[6:0], 1'b0};
            SEL_XNOR:   res = {1'b0, ~(op1 ^ op2)};
            SEL_DIV2:   res = {op1[0], op1[7], op1[7:1]};
            SEL_LOAD:   res = {1'b0, op2};
            SEL_STORE:  res = {1'b0, op1};
            // Carry out of ~op1 + 1 is set only when op1 is zero.
            SEL_COMP2S: res = {1'b0, ~op1} + 9'd1;
            SEL_ROUND:  res = {round_sum[8:3], 3'b000};
            default:    res = 9'd0;
        endcase
        co_d  = res[8];
        out_d = res[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 8'h00;
            co_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            co_q  <= co_d;
        end
    end

    assign out = out_q;
    assign co  = co_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed table-driven bench for alu
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [2:0] sel;
    logic [7:0] out;
    logic       co;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] exp_out;
        logic       exp_co;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .op1  (op1),
        .op2  (op2),
        .sel  (sel),
        .out  (out),
        .co   (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] exp_out, input logic exp_co);
        n_cmp++;
        if (out !== exp_out || co !== exp_co) begin
            n_bad++;
            $display("FAIL %s: got out=%02h co=%0b, expected out=%02h co=%0b",
                     name, out, co, exp_out, exp_co);
        end
    endtask

    task automatic add_vec(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eo, input logic ec);
        vec_t v;
        v.sel = s; v.op1 = a; v.op2 = b; v.exp_out = eo; v.exp_co = ec;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        add_vec(3'b000, 8'h01, 8'h02, 8'h03, 1'b0);
        add_vec(3'b000, 8'h81, 8'h82, 8'h03, 1'b1);
        add_vec(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
        add_vec(3'b000, 8'h7F, 8'h80, 8'hFF, 1'b0);
        add_vec(3'b001, 8'h01, 8'hFF, 8'h02, 1'b0);
        add_vec(3'b001, 8'h80, 8'h55, 8'h00, 1'b1);
        add_vec(3'b001, 8'hC3, 8'h00, 8'h86, 1'b1);
        add_vec(3'b010, 8'hFE, 8'h02, 8'h03, 1'b0);
        add_vec(3'b010, 8'h00, 8'h00, 8'hFF, 1'b0);
        add_vec(3'b010, 8'hA5, 8'h5A, 8'h00, 1'b0);
        add_vec(3'b011, 8'h09, 8'hAA, 8'h04, 1'b1);
        add_vec(3'b011, 8'h88, 8'h00, 8'hC4, 1'b0);
        add_vec(3'b011, 8'hFF, 8'h00, 8'hFF, 1'b1);
        add_vec(3'b100, 8'h01, 8'h02, 8'h02, 1'b0);
        add_vec(3'b101, 8'h01, 8'h02, 8'h01, 1'b0);
        add_vec(3'b101, 8'hE7, 8'h33, 8'hE7, 1'b0);
        add_vec(3'b110, 8'h01, 8'h77, 8'hFF, 1'b0);
        add_vec(3'b110, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b110, 8'h80, 8'h00, 8'h80, 1'b0);
        add_vec(3'b110, 8'h05, 8'h00, 8'hFB, 1'b0);
        add_vec(3'b111, 8'h0C, 8'h00, 8'h10, 1'b0);
        add_vec(3'b111, 8'h0A, 8'hFF, 8'h10, 1'b0);
        add_vec(3'b111, 8'h10, 8'h00, 8'h10, 1'b0);
        add_vec(3'b111, 8'hFA, 8'h00, 8'h00, 1'b1);
        add_vec(3'b111, 8'hF8, 8'h00, 8'hF8, 1'b0);
        add_vec(3'b111, 8'hF9, 8'h00, 8'h00, 1'b1);
        add_vec(3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
        add_vec(3'b111, 8'h01, 8'h00, 8'h08, 1'b0);

        // Reset state with inputs that would otherwise produce a nonzero result.
        rst_n = 1'b0;
        sel = 3'b000; op1 = 8'hFF; op2 = 8'hFF;
        #1;
        check("reset_async", 8'h00, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_held", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            sel = vecs[i].sel; op1 = vecs[i].op1; op2 = vecs[i].op2;
            @(posedge clk); #1;
            check($sformatf("vec%0d_sel%0d_op1_%02h", i, vecs[i].sel, vecs[i].op1),
                  vecs[i].exp_out, vecs[i].exp_co);
        end

        // Inputs changed between edges must not reach out before the next edge.
        @(negedge clk);
        sel = 3'b000; op1 = 8'h10; op2 = 8'h20;
        @(posedge clk); #1;
        check("mid_first", 8'h30, 1'b0);
        #2;
        sel = 3'b101; op1 = 8'h55; op2 = 8'h00;
        #1;
        check("mid_hold", 8'h30, 1'b0);
        @(negedge clk); #1;
        check("mid_hold_neg", 8'h30, 1'b0);
        @(posedge clk); #1;
        check("mid_update", 8'h55, 1'b0);

        // Asynchronous reset in the high phase, release in the high phase.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", 8'h00, 1'b0);
        @(negedge clk);
        sel = 3'b000; op1 = 8'h81; op2 = 8'h82;
        @(posedge clk); #1;
        check("rst_mid_discard", 8'h00, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_release_hold", 8'h00, 1'b0);
        @(posedge clk); #1;
        check("rst_first_result", 8'h03, 1'b1);

        // Reset pulse entirely within the low phase, released before the edge.
        @(negedge clk); #1;
        rst_n = 1'b0;
        sel = 3'b110; op1 = 8'h00;
        #1;
        check("rst_low_phase", 8'h00, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_low_release", 8'h00, 1'b0);
        @(posedge clk); #1;
        check("rst_low_result", 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: ALU

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 op1  input  8  first operand, unsigned bit vector unless an operation states otherwise.
REQ-004 op2  input  8  second operand.
REQ-005 sel  input  3  operation select, per REQ-011..REQ-018.
REQ-006 out  output  8  registered result.
REQ-007 co  output  1  registered carry/flag bit.

Function
REQ-008 out and co SHALL be registers loaded on every rising clk edge while rst_n=1; no enable, no handshake.
REQ-009 Latency SHALL be exactly 1 cycle: result of op1/op2/sel sampled at edge N appears on out/co after edge N and holds until edge N+1.
REQ-010 Result logic SHALL be purely combinational from op1, op2, sel; no other internal state.
REQ-011 sel=000 ADD: {co,out} = op1 + op2, 9-bit sum; co = carry out of bit 7.
REQ-012 sel=001 ASHL: out = {op1[6:0],1'b0} (shift by exactly 1, op2 ignored); co = op1[7].
REQ-013 sel=010 XNOR: out = ~(op1 ^ op2) bitwise; co = 0.
REQ-014 sel=011 DIV2: arithmetic right shift by 1, out = {op1[7],op1[7:1]} (sign preserved); co = op1[0] (remainder bit).
REQ-015 sel=100 LOAD: out = op2; co = 0.
REQ-016 sel=101 STORE: out = op1; co = 0.
REQ-017 sel=110 COMP2S: {co,out} = {1'b0,~op1} + 1; out is two's complement of op1; co = 1 only when op1 = 0x00.
REQ-018 sel=111 ROUND: round op1 up to next multiple of 8: {co,out} = ({1'b0,op1} + 7) with low 3 bits of out forced to 0; multiples of 8 unchanged; co = 1 on overflow (op1 >= 0xF9 gives out = 0x00, co = 1).
REQ-019 All arithmetic SHALL wrap modulo 256 on out; overflow indicated only via co as specified per operation.
REQ-020 op2 SHALL be ignored for every sel except 000, 010, 100.
REQ-021 A sel or operand change between edges SHALL have no effect on out/co until the next rising edge.

Reset
REQ-022 rst_n=0 SHALL immediately (without clk) force out=0x00 and co=0, and hold them while low.
REQ-023 Reset asserted mid-sequence SHALL discard the pending result; first result after release appears at the first rising edge with rst_n=1.
REQ-024 Reset release SHALL be clean in any clock phase; no spurious value other than 0 or the correctly computed result.

Verification
REQ-025 ADD: op1=0x01, op2=0x02, sel=000 -> out=0x03, co=0; op1=0x81, op2=0x82 -> out=0x03, co=1.
REQ-026 Shifts: ASHL op1=0x01 -> out=0x02, co=0; ASHL op1=0x80 -> out=0x00, co=1; DIV2 op1=0x09 -> out=0x04, co=1; DIV2 op1=0x88 -> out=0xC4, co=0.
REQ-027 Logic/move: XNOR op1=0xFE, op2=0x02 -> out=0x03, co=0; LOAD op1=0x01, op2=0x02 -> out=0x02; STORE same operands -> out=0x01, co=0.
REQ-028 COMP2S: op1=0x01 -> out=0xFF, co=0; op1=0x00 -> out=0x00, co=1; op1=0x80 -> out=0x80, co=0.
REQ-029 ROUND: op1=0x0C -> 0x10; op1=0x0A -> 0x10; op1=0x10 -> 0x10, co=0; op1=0xFA -> out=0x00, co=1.
REQ-030 Timing/reset: inputs changed mid-cycle -> out updates only at next rising edge; rst_n pulled low between edges -> out=0x00, co=0 immediately, independent of clk.
